exec_pc_unit: RTL and testbench

Combined execute-stage and program-counter block for the single-cycle LEGv8-style datapath. It decodes a 4-bit ALU operation from the instruction opcode and the controller's ALUOp. It performs 32-bit signed ALU arithmetic and logic, producing result, overflow and zero flags. It holds the PC register, advancing it sequentially or by a branch offset. The PC output addresses instruction memory; the ALU result feeds data memory and the write-back mux.

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/exec_pc_unit_if.sv | 33 +++
 rtl/exec_pc_unit_alu_core.sv | 53 +++++
 rtl/exec_pc_unit.sv | 60 ++++++
 tb/tb_exec_pc_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/PC block.
//   - ALU control codes driven from the decoder into alu_core
//   - ALUOp encodings produced by the main decoder
//   - R-type opcode constants (instruction[31:21])
//   - decode_alu_control(): ALUOp + opcode -> 4-bit ALU control
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_ctl_e;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;  // load/store address add
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;  // pass operand B for zero test
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // 2'b11 is decoded the same way

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    // Unknown R-type opcodes fall back to add so the datapath still
    // produces a defined value.
    function automatic logic [3:0] decode_alu_control(input logic [1:0]  alu_op,
                                                      input logic [10:0] opcode);
        logic [3:0] ctl;
        ctl = ALU_ADD;
        if (alu_op == ALUOP_MEM) begin
            ctl = ALU_ADD;
        end else if (alu_op == ALUOP_CBZ) begin
            ctl = ALU_PASSB;
        end else begin
            case (opcode)
                OP_ADD:  ctl = ALU_ADD;
                OP_SUB:  ctl = ALU_SUB;
                OP_AND:  ctl = ALU_AND;
                OP_ORR:  ctl = ALU_OR;
                default: ctl = ALU_ADD;
            endcase
        end
        return ctl;
    endfunction

endpackage

// File: rtl/exec_pc_unit_if.sv
// Signal bundle between the controller/register file and exec_pc_unit.
// There is no handshake: every input is sampled combinationally, and
// only pc is registered (on the rising clock edge).
//   master : drives instruction, alu_op, data1, data2, immediate,
//            uncond_branch, branch; observes the results
//   slave  : the execute/PC block itself
interface exec_pc_unit_if #(parameter int WIDTH = 32);

    logic [31:0]             instruction;
    logic [1:0]              alu_op;
    logic signed [WIDTH-1:0] data1;
    logic signed [WIDTH-1:0] data2;
    logic signed [WIDTH-1:0] immediate;
    logic                    uncond_branch;
    logic                    branch;

    logic [3:0]              alu_control;
    logic signed [WIDTH-1:0] alu_result;
    logic                    overflow;
    logic                    zero_flag;
    logic [WIDTH-1:0]        pc;

    modport master (
        output instruction, alu_op, data1, data2, immediate, uncond_branch, branch,
        input  alu_control, alu_result, overflow, zero_flag, pc
    );

    modport slave (
        input  instruction, alu_op, data1, data2, immediate, uncond_branch, branch,
        output alu_control, alu_result, overflow, zero_flag, pc
    );

endinterface

// File: rtl/exec_pc_unit_alu_core.sv
// Combinational two's-complement ALU.
//   op       : 4-bit ALU control code (exec_pkg::alu_ctl_e values)
//   a, b     : signed operands
//   result   : selected operation, wraps modulo 2^WIDTH
//   overflow : signed overflow, only for add/sub
//   zero     : result == 0, for every operation
module alu_core
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    zero
);

    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD: begin
                result   = sum;
                // Same-sign operands producing an opposite-sign sum.
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                // Mixed-sign operands whose difference flips away from A.
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_PASSB: result = b;
            ALU_NOR:   result = ~(a | b);
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exec_pc_unit.sv
// Execute stage plus program counter of the single-cycle datapath.
//   clock, reset : rising-edge clock; asynchronous active-high reset of pc
//   bus (slave)  : instruction/alu_op/operands/branch controls in;
//                  alu_control, alu_result, overflow, zero_flag, pc out
// ALU control decode and the PC register live here; the arithmetic is
// in alu_core. Everything except pc is purely combinational.
module exec_pc_unit
    import exec_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int               PC_STEP  = 4
) (
    input  logic           clock,
    input  logic           reset,
    exec_pc_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    logic [10:0]      opcode;
    logic [3:0]       alu_control;
    logic             zero_flag;
    logic             take_branch;
    logic [WIDTH-1:0] branch_offset;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;

    assign opcode      = bus.instruction[31:21];
    assign alu_control = decode_alu_control(bus.alu_op, opcode);

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op       (alu_control),
        .a        (bus.data1),
        .b        (bus.data2),
        .result   (bus.alu_result),
        .overflow (bus.overflow),
        .zero     (zero_flag)
    );

    // CBZ relies on the ALU passing data2 through, so zero_flag is the
    // register-is-zero test. An unconditional branch wins outright.
    assign take_branch   = bus.uncond_branch | (bus.branch & zero_flag);
    // Offset is in instruction words; bits shifted out simply wrap.
    assign branch_offset = WIDTH'(bus.immediate) << 2;
    assign pc_next       = take_branch ? (pc_q + branch_offset) : (pc_q + STEP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign bus.alu_control = alu_control;
    assign bus.zero_flag   = zero_flag;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_exec_pc_unit.sv
// Bench for exec_pc_unit: directed and random ALU/decode vectors, a
// direct alu_core instance for codes the decoder never emits, and a
// PC sequence covering reset, stepping, CBZ, B, self-loop and wrap.
module tb_exec_pc_unit;
    import exec_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exec_pc_unit_if #(.WIDTH(W)) bus ();

    exec_pc_unit #(.WIDTH(W), .PC_RESET('0), .PC_STEP(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Standalone ALU for NOR and undefined codes.
    logic [3:0]          sa_op;
    logic signed [W-1:0] sa_a, sa_b, sa_res;
    logic                sa_ovf, sa_zero;

    alu_core #(.WIDTH(W)) u_sa_alu (
        .op       (sa_op),
        .a        (sa_a),
        .b        (sa_b),
        .result   (sa_res),
        .overflow (sa_ovf),
        .zero     (sa_zero)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [W-1:0] obs);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", W'(exp_q.size()), 1);
        end else begin
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_ctl(input logic [1:0] aop, input logic [10:0] opc);
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0111;
        if (opc == 11'b10001011000) return 4'b0010;
        if (opc == 11'b11001011000) return 4'b0110;
        if (opc == 11'b10001010000) return 4'b0000;
        if (opc == 11'b10101010000) return 4'b0001;
        return 4'b0010;
    endfunction

    // Overflow from a 33-bit sign-extended result: top two bits disagree.
    task automatic model_alu(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic ov);
        logic [W:0] w;
        r  = '0;
        ov = 1'b0;
        case (ctl)
            4'b0010: begin w = {a[W-1], a} + {b[W-1], b}; r = w[W-1:0]; ov = w[W] ^ w[W-1]; end
            4'b0110: begin w = {a[W-1], a} - {b[W-1], b}; r = w[W-1:0]; ov = w[W] ^ w[W-1]; end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = b;
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
    endtask

    // ---------------- drivers ----------------
    task automatic alu_vec(input string tag, input logic [1:0] aop, input logic [10:0] opc,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] e_ctl, input logic [W-1:0] e_res,
                           input logic e_ovf, input logic e_zero);
        @(negedge clock);
        bus.alu_op        = aop;
        bus.instruction   = {opc, 21'($urandom_range(0, 2097151))};
        bus.data1         = a;
        bus.data2         = b;
        bus.uncond_branch = 1'b0;
        bus.branch        = 1'b0;
        push_exp({tag, "_ctl"}, W'(e_ctl));
        push_exp({tag, "_res"}, e_res);
        push_exp({tag, "_ovf"}, W'(e_ovf));
        push_exp({tag, "_zero"}, W'(e_zero));
        #1;
        pop_check(W'(bus.alu_control));
        pop_check(bus.alu_result);
        pop_check(W'(bus.overflow));
        pop_check(W'(bus.zero_flag));
    endtask

    task automatic core_vec(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] e_res,
                            input logic e_ovf, input logic e_zero);
        @(negedge clock);
        sa_op = op;
        sa_a  = a;
        sa_b  = b;
        push_exp({tag, "_res"}, e_res);
        push_exp({tag, "_ovf"}, W'(e_ovf));
        push_exp({tag, "_zero"}, W'(e_zero));
        #1;
        pop_check(sa_res);
        pop_check(W'(sa_ovf));
        pop_check(W'(sa_zero));
    endtask

    task automatic step_pc(input string tag, input logic ub, input logic br, input logic [1:0] aop,
                           input logic [W-1:0] d2, input logic [W-1:0] imm, input logic [W-1:0] e_pc);
        @(negedge clock);
        reset             = 1'b0;
        bus.uncond_branch = ub;
        bus.branch        = br;
        bus.alu_op        = aop;
        bus.instruction   = '0;
        bus.data1         = 32'h1234_5678;
        bus.data2         = d2;
        bus.immediate     = imm;
        push_exp(tag, e_pc);
        @(posedge clock);
        #1;
        pop_check(bus.pc);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    logic [10:0] opc_tab [5];
    initial begin
        opc_tab[0] = OP_ADD;
        opc_tab[1] = OP_SUB;
        opc_tab[2] = OP_AND;
        opc_tab[3] = OP_ORR;
        opc_tab[4] = 11'b11111111111;

        reset             = 1'b1;
        bus.instruction   = '0;
        bus.alu_op        = 2'b00;
        bus.data1         = '0;
        bus.data2         = '0;
        bus.immediate     = '0;
        bus.uncond_branch = 1'b0;
        bus.branch        = 1'b0;
        sa_op = 4'b0000;
        sa_a  = '0;
        sa_b  = '0;

        repeat (2) @(negedge clock);
        check_val("pc_reset", bus.pc, 32'h0);

        // Decode and ALU values (reset held, so pc stays put)
        alu_vec("add",     2'b10, OP_ADD, 32'd7, -32'sd3, 4'b0010, 32'd4, 1'b0, 1'b0);
        alu_vec("sub",     2'b10, OP_SUB, 32'd5, 32'd5,   4'b0110, 32'd0, 1'b0, 1'b1);
        alu_vec("and",     2'b10, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000, 32'h0000_00F0, 1'b0, 1'b0);
        alu_vec("orr",     2'b10, OP_ORR, 32'h0000_F000, 32'h0000_000F, 4'b0001, 32'h0000_F00F, 1'b0, 1'b0);
        alu_vec("unk_op",  2'b10, 11'b11111111111, 32'd10, 32'd20, 4'b0010, 32'd30, 1'b0, 1'b0);
        alu_vec("aluop00", 2'b00, OP_SUB, 32'h100, 32'h20, 4'b0010, 32'h120, 1'b0, 1'b0);
        alu_vec("cbz_z",   2'b01, OP_ADD, 32'd9, 32'd0, 4'b0111, 32'd0, 1'b0, 1'b1);
        alu_vec("cbz_nz",  2'b01, OP_ADD, 32'd0, 32'd5, 4'b0111, 32'd5, 1'b0, 1'b0);
        alu_vec("aluop11", 2'b11, OP_SUB, 32'd3, 32'd1, 4'b0110, 32'd2, 1'b0, 1'b0);
        alu_vec("add_ovf", 2'b10, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b1, 1'b0);
        alu_vec("sub_ovf", 2'b10, OP_SUB, 32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0);
        alu_vec("neg1p1",  2'b10, OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'h0, 1'b0, 1'b1);

        // Random R-type vectors against the model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   aop;
            logic [10:0]  opc;
            logic [W-1:0] a, b, r;
            logic [3:0]   c;
            logic         ov;
            aop = 2'($urandom_range(2, 3));
            opc = opc_tab[$urandom_range(0, 4)];
            a   = $urandom();
            b   = (i % 4 == 0) ? a : $urandom();
            c   = model_ctl(aop, opc);
            model_alu(c, a, b, r, ov);
            alu_vec($sformatf("rnd%0d", i), aop, opc, a, b, c, r, ov, (r == '0));
        end

        // Codes the decoder never produces
        core_vec("nor0",   4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        core_vec("nor1",   4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b1);
        core_vec("undef",  4'b1111, 32'd5, 32'd3, 32'h0, 1'b0, 1'b1);
        core_vec("undef3", 4'b0011, 32'h7FFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b1);

        check_val("pc_held", bus.pc, 32'h0);

        // PC sequence
        step_pc("b_to_40", 1'b1, 1'b0, 2'b00, 32'd0, 32'd16, 32'h40);

        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_val("pc_async", bus.pc, 32'h0);
        @(posedge clock);
        #1 check_val("pc_rst_hold", bus.pc, 32'h0);

        step_pc("seq4",    1'b0, 1'b0, 2'b01, 32'd0, 32'd7, 32'h4);
        step_pc("seq8",    1'b0, 1'b0, 2'b01, 32'd0, 32'd7, 32'h8);
        step_pc("seq12",   1'b0, 1'b0, 2'b01, 32'd0, 32'd7, 32'hC);
        step_pc("b_to_20", 1'b1, 1'b0, 2'b00, 32'd9, 32'd5, 32'h20);
        step_pc("cbz_tk",  1'b0, 1'b1, 2'b01, 32'd0, 32'd3, 32'h2C);
        step_pc("b_back1", 1'b1, 1'b0, 2'b00, 32'd9, -32'sd3, 32'h20);
        step_pc("cbz_nt",  1'b0, 1'b1, 2'b01, 32'd5, 32'd3, 32'h24);
        step_pc("b_back2", 1'b1, 1'b0, 2'b00, 32'd9, -32'sd1, 32'h20);
        step_pc("b_neg2",  1'b1, 1'b0, 2'b00, 32'd9, -32'sd2, 32'h18);
        step_pc("both",    1'b1, 1'b1, 2'b01, 32'd5, 32'd2, 32'h20);
        step_pc("self",    1'b1, 1'b0, 2'b00, 32'd9, 32'd0, 32'h20);
        step_pc("wrap_b",  1'b1, 1'b0, 2'b00, 32'd9, -32'sd9, 32'hFFFF_FFFC);
        step_pc("wrap_s",  1'b0, 1'b0, 2'b00, 32'd9, 32'd0, 32'h0);

        check_val("sb_drained", W'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
